// File: rtl/ram_pkg.sv
// Shared definitions for the pipelined RAM: FSM state encoding and
// read/write direction constants.
package ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage : ram_pkg

// File: rtl/ram_if.sv
// Request/response bus of the pipelined RAM. The master (load/store unit)
// drives requests and the clear strobe; the slave (RAM) returns ready,
// read data and the range error flag.
interface ram_if #(
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned ADDRESS_SIZE = 16
);
    logic                      enable;
    logic                      read_write;
    logic [ADDRESS_SIZE-1:0]   address;
    logic [DATA_SIZE-1:0]      data_in;
    logic [DATA_SIZE/8-1:0]    byte_en;
    logic                      clear;
    logic                      ready;
    logic [DATA_SIZE-1:0]      data_out;
    logic                      data_valid;
    logic                      error;

    modport master (
        output enable, read_write, address, data_in, byte_en, clear,
        input  ready, data_out, data_valid, error
    );

    modport slave (
        input  enable, read_write, address, data_in, byte_en, clear,
        output ready, data_out, data_valid, error
    );
endinterface : ram_if

// File: rtl/ram_read_pipe.sv
// LATENCY-deep delay line for read responses. Each stage only loads new
// data when its incoming valid is set, so the final stage holds the last
// delivered word between responses. The error bit is qualified by valid.
module ram_read_pipe #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 err_i,
    output logic                 valid_o,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 err_o
);
    logic                 valid_q [LATENCY];
    logic [DATA_SIZE-1:0] data_q  [LATENCY];
    logic                 err_q   [LATENCY];

    // Shift responses one stage per clock; reset flushes everything in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                err_q[k]   <= 1'b0;
            end
        end else begin
            valid_q[0] <= valid_i;
            err_q[0]   <= valid_i && err_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int unsigned k = 1; k < LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                err_q[k]   <= err_q[k-1];
                if (valid_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];
    assign err_o   = err_q[LATENCY-1];

endmodule : ram_read_pipe

// File: rtl/ram_pipelined.sv
// Clocked single-port RAM with enable/ready handshake, byte-masked writes,
// registered reads of configurable latency, out-of-range error reporting
// and a hardware zero-fill sweep. The storage array mem is not reset so it
// can be preloaded externally.
module ram_pipelined
  import ram_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned ADDRESS_SIZE = 16,
  parameter int unsigned MEM_DEPTH    = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic  clock,
  input logic  reset,
  ram_if.slave bus
);
  localparam int unsigned BYTES = DATA_SIZE / 8;
  localparam int unsigned CNT_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDRESS_SIZE:0] ADDR_LIM = (ADDRESS_SIZE + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_DEPTH - 1);

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wr_err_q, wr_err_d;

  logic                 accept;
  logic                 rd_req;
  logic                 wr_req;
  logic                 in_range;
  logic [CNT_W-1:0]     idx;
  logic [DATA_SIZE-1:0] rd_word;
  logic [DATA_SIZE-1:0] wr_word;

  logic                 pipe_valid;
  logic [DATA_SIZE-1:0] pipe_data;
  logic                 pipe_err;

  // Range check is done on the full-width address so aliases above MEM_DEPTH are caught.
  assign in_range = {1'b0, bus.address} < ADDR_LIM;
  assign idx      = bus.address[CNT_W-1:0];

  assign bus.ready = (state_q == ST_IDLE) && !bus.clear;
  assign accept    = bus.enable && bus.ready;
  assign rd_req    = accept && (bus.read_write == RW_READ);
  assign wr_req    = accept && (bus.read_write == RW_WRITE);

  // Read data is sampled at the accept edge; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = mem[idx];
    end
  end

  // Merge enabled bytes of data_in into the currently stored word.
  always_comb begin
    wr_word = '0;
    if (in_range) begin
      wr_word = mem[idx];
    end
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (bus.byte_en[b]) begin
        wr_word[8*b +: 8] = bus.data_in[8*b +: 8];
      end
    end
  end

  // Storage update: the clear sweep owns the port while active, otherwise accepted writes.
  always_ff @(posedge clock) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_req && in_range && !reset) begin
      mem[idx] <= wr_word;
    end
  end

  // Next-state logic for the idle/clear FSM and sweep counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_err_d = wr_req && !in_range;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, sweep counter and write-error pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
    end
  end

  ram_read_pipe #(
    .DATA_SIZE (DATA_SIZE),
    .LATENCY   (READ_LATENCY)
  ) u_read_pipe (
    .clock   (clock),
    .reset   (reset),
    .valid_i (rd_req),
    .data_i  (rd_word),
    .err_i   (!in_range),
    .valid_o (pipe_valid),
    .data_o  (pipe_data),
    .err_o   (pipe_err)
  );

  assign bus.data_out   = pipe_data;
  assign bus.data_valid = pipe_valid;
  assign bus.error      = pipe_err || wr_err_q;

endmodule : ram_pipelined
